ultrasonic_ranger: RTL and testbench

Trigger/echo driver for the HC‑SR04‑style proximity sensor behind the pet's `echo_sig` "play" input. It periodically emits the trigger pulse, times the returning echo pulse, converts the width to centimetres and publishes a distance, a one‑cycle `valid` strobe and a `near` level. The game state machine consumes `near` in place of the raw echo line.

---
 rtl/ultrasonic_ranger.sv | 207 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_ranger
// Purpose  : Trigger/echo driver for an HC-SR04-style proximity sensor.
//            Periodically fires the trigger pulse and times the returning
//            echo. It converts the echo width to centimetres and publishes
//            a distance, a one-cycle valid strobe, a near level and a
//            timeout flag.
// Ports    : clk          - system clock
//            rst          - synchronous active-high reset
//            enable       - run periodic measurements while high
//            echo         - asynchronous echo pin from the sensor
//            trig         - registered trigger output
//            distance_cm  - last result in cm (511 on timeout / saturation)
//            valid        - one-cycle strobe when the result outputs update
//            near         - last result below NEAR_CM and not a timeout
//            timeout      - last measurement timed out
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2900,
  parameter int TIMEOUT_CYCLES = 1_250_000,
  parameter int PERIOD_CYCLES  = 3_000_000,
  parameter int NEAR_CM        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       echo,
  output logic       trig,
  output logic [8:0] distance_cm,
  output logic       valid,
  output logic       near,
  output logic       timeout
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(CM_CYCLES + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SUB_LAST    = SW'(CM_CYCLES - 1);
  localparam logic [8:0]    CM_MAX      = 9'd511;
  localparam logic [9:0]    NEAR_LIM    = 10'(NEAR_CM);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_ECHO = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            echo_meta_q, echo_s_q, echo_d_q;
  logic [PW-1:0]   period_cnt_q, period_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]   sub_cnt_q, sub_cnt_d;
  logic [8:0]      cm_cnt_q, cm_cnt_d;
  logic            trig_q;
  logic [8:0]      dist_q, dist_d;
  logic            near_q, near_d;
  logic            tmo_flag_q, tmo_flag_d;
  logic            valid_q, valid_d;

  logic            w_rise, w_fall, w_tmo_hit, w_period_done, w_sub_wrap;
  logic [SW-1:0]   w_sub_base, w_sub_inc;
  logic [8:0]      w_cm_base, w_cm_inc;

  assign w_rise        = echo_s_q & ~echo_d_q;
  assign w_fall        = ~echo_s_q & echo_d_q;
  assign w_tmo_hit     = (tmo_cnt_q == TMO_LAST);
  assign w_period_done = (period_cnt_q == PERIOD_LAST);

  // The rise cycle already has echo_s high, so it is counted as the first
  // high cycle: on MEASURE entry the counters load "zero plus one step".
  // This makes an N-cycle echo report exactly floor(N / CM_CYCLES).
  assign w_sub_base = (state_q == S_MEASURE) ? sub_cnt_q : '0;
  assign w_cm_base  = (state_q == S_MEASURE) ? cm_cnt_q  : '0;
  assign w_sub_wrap = (w_sub_base == SUB_LAST);
  assign w_sub_inc  = w_sub_wrap ? '0 : w_sub_base + 1'b1;
  assign w_cm_inc   = (w_sub_wrap && (w_cm_base != CM_MAX)) ? w_cm_base + 1'b1
                                                            : w_cm_base;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = w_period_done ? period_cnt_q : period_cnt_q + 1'b1;
    tmo_cnt_d    = tmo_cnt_q;
    sub_cnt_d    = sub_cnt_q;
    cm_cnt_d     = cm_cnt_q;
    dist_d       = dist_q;
    near_d       = near_q;
    tmo_flag_d   = tmo_flag_q;
    valid_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d      = S_TRIG;
          period_cnt_d = '0;
        end
      end

      // period_cnt starts at 0 on TRIG entry, so it doubles as the pulse timer.
      S_TRIG: begin
        if (period_cnt_q == TRIG_LAST) begin
          state_d   = S_WAIT_ECHO;
          tmo_cnt_d = '0;
        end
      end

      S_WAIT_ECHO: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (w_rise) begin
          state_d   = S_MEASURE;
          sub_cnt_d = w_sub_inc;
          cm_cnt_d  = w_cm_inc;
        end else if (w_tmo_hit) begin
          state_d    = S_HOLDOFF;
          dist_d     = CM_MAX;
          near_d     = 1'b0;
          tmo_flag_d = 1'b1;
          valid_d    = 1'b1;
        end
      end

      S_MEASURE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (echo_s_q) begin
          sub_cnt_d = w_sub_inc;
          cm_cnt_d  = w_cm_inc;
        end
        // A fall coinciding with the timeout still yields a real distance.
        if (w_fall) begin
          state_d    = S_HOLDOFF;
          dist_d     = cm_cnt_q;
          near_d     = ({1'b0, cm_cnt_q} < NEAR_LIM);
          tmo_flag_d = 1'b0;
          valid_d    = 1'b1;
        end else if (w_tmo_hit) begin
          state_d    = S_HOLDOFF;
          dist_d     = CM_MAX;
          near_d     = 1'b0;
          tmo_flag_d = 1'b1;
          valid_d    = 1'b1;
        end
      end

      // A sensor still driving a stale echo must go quiet before re-triggering.
      S_HOLDOFF: begin
        if (w_period_done && !echo_s_q) begin
          if (enable) begin
            state_d      = S_TRIG;
            period_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      echo_meta_q  <= 1'b0;
      echo_s_q     <= 1'b0;
      echo_d_q     <= 1'b0;
      period_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      sub_cnt_q    <= '0;
      cm_cnt_q     <= '0;
      trig_q       <= 1'b0;
      dist_q       <= '0;
      near_q       <= 1'b0;
      tmo_flag_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      echo_meta_q  <= echo;
      echo_s_q     <= echo_meta_q;
      echo_d_q     <= echo_s_q;
      period_cnt_q <= period_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      cm_cnt_q     <= cm_cnt_d;
      trig_q       <= (state_q == S_TRIG);
      dist_q       <= dist_d;
      near_q       <= near_d;
      tmo_flag_q   <= tmo_flag_d;
      valid_q      <= valid_d;
    end
  end

  assign trig        = trig_q;
  assign distance_cm = dist_q;
  assign valid       = valid_q;
  assign near        = near_q;
  assign timeout     = tmo_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_ranger
// Purpose  : Self-checking bench for ultrasonic_ranger with small timing
//            parameters. Expected trigger times and results come from
//            cycle arithmetic on the sensor timing rules, not from the RTL.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_ranger;

  localparam int TRIG = 4;
  localparam int CM   = 10;
  localparam int TMO  = 300;
  localparam int PER  = 500;
  localparam int NEAR = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       echo = 1'b0;
  logic       trig, valid, near, timeout;
  logic [8:0] distance_cm;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int next_rise = 0;
  int last_rise = 0;

  int rise_q[$], fall_q[$], v_cyc[$], v_dist[$], v_near[$], v_tmo[$];
  logic trig_prev = 1'b0;

  ultrasonic_ranger #(
    .TRIG_CYCLES   (TRIG),
    .CM_CYCLES     (CM),
    .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES (PER),
    .NEAR_CM       (NEAR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .distance_cm(distance_cm),
    .valid      (valid),
    .near       (near),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle: trigger edges and every valid-high cycle.
  always @(negedge clk) begin
    if (trig === 1'b1 && trig_prev !== 1'b1) rise_q.push_back(cyc);
    if (trig !== 1'b1 && trig_prev === 1'b1) fall_q.push_back(cyc);
    trig_prev = trig;
    if (valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_dist.push_back(int'(distance_cm));
      v_near.push_back(int'(near));
      v_tmo.push_back(int'(timeout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output int r);
    int n = 0;
    while (rise_q.size() == 0 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    assert (rise_q.size() > 0) else begin
      errors++;
      $error("FAIL trig_rise_wait: observed no rise in %0d cycles expected one", n);
    end
    r = (rise_q.size() > 0) ? rise_q.pop_front() : cyc;
  endtask

  // One trigger/echo round. d: cycles from trigger fall to echo pin high,
  // n: echo width in cycles (0 = no echo), dis_off: cycles after echo rise
  // at which enable drops (-1 = never). Pin changes happen just after an edge.
  task automatic measure(input string tag, input int exp_rise, input int d,
                         input int n, input int dis_off);
    int r, a, w, ev, ed, en, et, stop, fw;
    int vc, vd, vn, vt;
    wait_rise(r);
    last_rise = r;
    check({tag, "_rise"}, r, exp_rise);
    while (cyc < r + TRIG + 2) tick();
    fw = -1;
    if (fall_q.size() > 0) fw = fall_q.pop_front() - r;
    check({tag, "_trig_width"}, fw, TRIG);

    a = r + TRIG + d;   // echo pin goes high just after edge a
    w = r + TRIG - 1;   // listening window opens one edge before trig drops
    // The echo reaches the synchronised domain two edges after a pin change
    // and its edge is acted on one edge later. A fall seen no later than
    // the final cycle of the window still gives a real distance.
    if (n > 0 && (a + n + 2) <= (w + TMO - 1)) begin
      ev = a + n + 3;
      ed = (n / CM > 511) ? 511 : n / CM;
      en = (ed < NEAR) ? 1 : 0;
      et = 0;
    end else begin
      ev = w + TMO;
      ed = 511;
      en = 0;
      et = 1;
    end
    // Next trigger: one period after this one, but not before echo is quiet.
    next_rise = r + PER;
    if (n > 0 && (a + n + 4) > next_rise) next_rise = a + n + 4;

    while (cyc < a) tick();
    if (n > 0) echo = 1'b1;
    stop = (((a + n) > (ev + 2)) ? (a + n) : (ev + 2)) + 1;
    while (cyc < stop) begin
      tick();
      if (cyc == a + n) echo = 1'b0;
      if (dis_off >= 0 && cyc == a + dis_off) enable = 1'b0;
    end

    check({tag, "_valid_count"}, v_cyc.size(), 1);
    vc = -1; vd = -1; vn = -1; vt = -1;
    if (v_cyc.size() > 0) begin
      vc = v_cyc.pop_front();
      vd = v_dist.pop_front();
      vn = v_near.pop_front();
      vt = v_tmo.pop_front();
    end
    check({tag, "_valid_cycle"}, vc, ev);
    check({tag, "_distance"}, vd, ed);
    check({tag, "_near"}, vn, en);
    check({tag, "_timeout"}, vt, et);
    v_cyc.delete(); v_dist.delete(); v_near.delete(); v_tmo.delete();
  endtask

  initial begin
    int c, r, d, n;

    // Reset state
    repeat (3) tick();
    check("rst_trig", trig, 0);
    check("rst_distance", distance_cm, 0);
    check("rst_valid", valid, 0);
    check("rst_near", near, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    repeat (4) tick();
    check("idle_trig", trig, 0);
    check("idle_no_rise", rise_q.size(), 0);

    // First measurement: trigger follows enable by one cycle
    enable = 1'b1;
    c = cyc;
    measure("m57", c + 2, 20, 57, -1);
    measure("m43", next_rise, 20, 43, -1);

    // Distance and near thresholds
    measure("m49", next_rise, 5, 49, -1);
    measure("m50", next_rise, 5, 50, -1);
    measure("m9",  next_rise, 7, 9, -1);
    measure("m10", next_rise, 7, 10, -1);

    // Randomised widths and delays, all within the timeout window
    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(3, 30));
      n = int'($urandom_range(1, 250));
      measure($sformatf("rnd%0d", i), next_rise, d, n, -1);
    end

    // Fall on the last window cycle versus one cycle late
    measure("edge_ok",  next_rise, 20, 276, -1);
    measure("edge_tmo", next_rise, 20, 277, -1);

    // No echo at all
    measure("no_echo", next_rise, 0, 0, -1);

    // Echo stuck high well past the period: trigger waits for it to drop
    measure("stuck", next_rise, 20, 576, -1);

    // Enable dropped mid-measurement: result still reported, then silence
    measure("dis", next_rise, 20, 60, 30);
    while (cyc < last_rise + 1200) tick();
    check("dis_no_more_trig", rise_q.size(), 0);
    check("dis_trig_low", trig, 0);

    // Reset during MEASURE: no result, outputs back to reset values
    fall_q.delete();
    enable = 1'b1;
    c = cyc;
    wait_rise(r);
    check("rstm_rise", r, c + 2);
    while (cyc < r + TRIG + 10) tick();
    echo = 1'b1;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    check("rstm_trig", trig, 0);
    check("rstm_distance", distance_cm, 0);
    check("rstm_valid", valid, 0);
    check("rstm_near", near, 0);
    check("rstm_timeout", timeout, 0);
    tick();
    rst = 1'b0;
    enable = 1'b0;
    echo = 1'b0;
    repeat (600) tick();
    check("rstm_no_valid", v_cyc.size(), 0);
    check("rstm_no_trig", rise_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
